// File: rtl/bch_pkg.sv
// bch_pkg: shared BCH(63,51) sizes, scheduler state encoding and data types
package bch_pkg;
  localparam int BCH_N = 63;
  localparam int BCH_K = 51;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} sched_state_t;
  typedef logic [BCH_K-1:0] msg_t;
  typedef logic [BCH_N-1:0] cw_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with pointer advance on accept
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      gid
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  // Winner is the first requester at or after ptr; scanning backwards leaves the nearest one
  always_comb begin
    gid = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) gid = j;
    end
    grant = (|req) ? NUM_REQ'(1) << gid : '0;
  end
  // Pointer moves one past the accepted winner so it is served last next round
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (accept) ptr <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
endmodule

// File: rtl/bch_enc_sched.sv
// bch_enc_sched: shares one bit-serial BCH encoder between several message sources
module bch_enc_sched
  import bch_pkg::*;
#(
  parameter int N = BCH_N,
  parameter int K = BCH_K,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*K-1:0] req_msg,
  input  logic                 enc_ready,
  output logic                 enc_valid,
  output logic                 enc_bit,
  input  logic                 enc_out_vld,
  input  logic                 enc_out_bit,
  output logic                 cw_valid,
  input  logic                 cw_ready,
  output logic [N-1:0]         cw_data,
  output logic [IW-1:0]        cw_id,
  output logic                 err_timeout
);
  localparam int CW = $clog2(K);
  localparam int OW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  sched_state_t state, state_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] gid;
  logic [K-1:0] msg_sr;
  logic [N-1:0] cw_sr;
  logic [IW-1:0] id;
  logic [CW-1:0] in_cnt;
  logic [OW-1:0] out_cnt, out_nxt;
  logic [TW-1:0] tmo_cnt;
  logic acc, xfer, cap, done, abort;
  assign acc = (state == IDLE) && |req_valid;
  assign xfer = (state == FEED) && enc_ready;
  assign cap = (state == FEED || state == DRAIN) && enc_out_vld && out_cnt != OW'(N);
  assign out_nxt = out_cnt + OW'(cap);
  assign done = out_nxt == OW'(N);
  assign abort = (state == DRAIN) && !enc_out_vld && tmo_cnt == TW'(TIMEOUT - 1) && !done;
  assign cw_data = cw_sr;
  assign cw_id = id;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .accept(acc),
    .grant(grant),
    .gid(gid)
  );
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // Next state: a full codeword wins over a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = acc ? FEED : IDLE;
      FEED:  state_nxt = (xfer && in_cnt == CW'(K - 1)) ? DRAIN : FEED;
      DRAIN: state_nxt = done ? OUT : abort ? IDLE : DRAIN;
      OUT:   state_nxt = cw_ready ? IDLE : OUT;
    endcase
  end
  // Outputs decoded from state; grant is also masked while reset is held
  always_comb begin
    req_ready = (state == IDLE && rst) ? grant : '0;
    enc_valid = state == FEED;
    enc_bit = enc_valid && msg_sr[K-1];
    cw_valid = state == OUT;
  end
  // Message/codeword shift registers, bit counters and the drain watchdog
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      msg_sr <= '0;
      cw_sr <= '0;
      id <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      tmo_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= abort;
      tmo_cnt <= (state == DRAIN && !enc_out_vld) ? tmo_cnt + 1'b1 : '0;
      if (acc) begin
        msg_sr <= req_msg[gid*K +: K];
        id <= gid;
        in_cnt <= '0;
        out_cnt <= '0;
        cw_sr <= '0;
      end
      if (xfer) begin
        msg_sr <= {msg_sr[K-2:0], 1'b0};
        in_cnt <= in_cnt + 1'b1;
      end
      if (cap) begin
        cw_sr <= {cw_sr[N-2:0], enc_out_bit};
        out_cnt <= out_nxt;
      end
      if (abort) cw_sr <= '0;
    end
endmodule

// File: tb/tb_bch_enc_sched.sv
// tb_bch_enc_sched: vector table plus scoreboard bench around a behavioural BCH(63,51) encoder
module tb_bch_enc_sched;
  typedef struct {
    int rid;
    logic [50:0] msg;
    logic [62:0] exp;
    bit tog;
  } vec_t;
  typedef struct {
    int id;
    logic [62:0] cw;
  } exp_t;
  logic clk = 0;
  logic rst;
  logic [1:0] req_valid, req_ready;
  logic [101:0] req_msg;
  logic enc_ready, enc_valid, enc_bit, enc_out_vld, enc_out_bit;
  logic cw_valid, cw_ready, err_timeout;
  logic [62:0] cw_data;
  logic [0:0] cw_id;
  int nasserts = 0, nfails = 0;
  int frames = 0, feed_cyc = 0, xfers = 0, rx_n = 0, emitted = 0, stop_at = -1;
  bit flush = 0, rdy_mode = 0;
  logic [50:0] rx = '0, rx_last = '0;
  bit oq[$];
  exp_t sb[$];
  int glog[$];
  vec_t vecs[5];

  bch_enc_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_msg(req_msg),
    .enc_ready(enc_ready), .enc_valid(enc_valid), .enc_bit(enc_bit),
    .enc_out_vld(enc_out_vld), .enc_out_bit(enc_out_bit),
    .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_id(cw_id),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Golden systematic BCH(63,51) encoder, g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1
  function automatic logic [62:0] bch_cw(input logic [50:0] m);
    logic [11:0] r;
    logic fb;
    r = '0;
    for (int i = 50; i >= 0; i--) begin
      fb = m[i] ^ r[11];
      r = {r[10:0], 1'b0} ^ (fb ? 12'h539 : 12'h000);
    end
    return {m, r};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    nasserts++;
    if (!ok) begin
      nfails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  // Encoder model: echoes each accepted bit one cycle later, then its 12 parity bits
  initial begin
    logic [62:0] c;
    enc_ready = 0;
    enc_out_vld = 0;
    enc_out_bit = 0;
    forever begin
      @(negedge clk);
      if (flush) begin
        oq.delete();
        rx_n = 0;
      end
      enc_ready = (rdy_mode && enc_valid) ? ~enc_ready : 1'b1;
      if (oq.size() > 0 && (stop_at < 0 || emitted < stop_at)) begin
        enc_out_vld = 1;
        enc_out_bit = oq.pop_front();
        emitted++;
      end else begin
        enc_out_vld = 0;
        enc_out_bit = 0;
      end
      #1;
      if (rst && enc_valid && enc_ready) begin
        if (rx_n == 0) emitted = 0;
        rx = {rx[49:0], enc_bit};
        rx_n++;
        xfers++;
        oq.push_back(enc_bit);
        if (rx_n == 51) begin
          c = bch_cw(rx);
          for (int i = 11; i >= 0; i--) oq.push_back(c[i]);
          rx_last = rx;
          rx_n = 0;
        end
      end
    end
  end

  // Monitor: pushes the expected codeword at grant, checks it at the output handshake
  initial begin
    int g;
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        if (req_ready != 0) begin
          chk($onehot(req_ready), "grant_onehot", req_ready, 1);
          g = req_ready[1] ? 1 : 0;
          sb.push_back('{g, bch_cw(req_msg[g*51 +: 51])});
          glog.push_back(g);
          feed_cyc = 0;
        end
        if (enc_valid) feed_cyc++;
        if (cw_valid && cw_ready) begin
          if (sb.size() == 0) chk(0, "sb_unexpected_cw", cw_data, 0);
          else begin
            e = sb.pop_front();
            chk(cw_data == e.cw, "sb_cw_data", cw_data, e.cw);
            chk(cw_id == 1'(e.id), "sb_cw_id", cw_id, e.id);
          end
          frames++;
        end
      end
    end
  end

  task automatic run_frame(input int rid, input logic [50:0] msg, input logic [62:0] exp, input bit tog);
    int n, x0, feed;
    feed = tog ? 102 : 51;
    rdy_mode = tog;
    x0 = xfers;
    req_msg[rid*51 +: 51] = msg;
    req_valid[rid] = 1'b1;
    cyc();
    req_valid[rid] = 1'b0;
    n = 0;
    while (!cw_valid && n < 400) begin
      cyc();
      n++;
    end
    chk(cw_valid, "frame_done", cw_valid, 1);
    chk(n == feed + 13, "latency", n, feed + 13);
    chk(cw_data == exp, "vec_cw_data", cw_data, exp);
    chk(cw_id == 1'(rid), "vec_cw_id", cw_id, rid);
    chk(cw_data[62:12] == msg, "systematic", cw_data[62:12], msg);
    chk(rx_last == msg, "enc_bit_seq", rx_last, msg);
    chk(xfers - x0 == 51, "transfers", xfers - x0, 51);
    chk(feed_cyc == feed, "feed_cycles", feed_cyc, feed);
    cyc();
    chk(!cw_valid, "cw_valid_drop", cw_valid, 0);
    rdy_mode = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f0, g0;
    logic [50:0] m0, m1;
    logic [62:0] e0;
    vecs[0] = '{0, 51'h0, 63'h0, 1'b0};
    vecs[1] = '{0, 51'b011011011110110110001111011001011110011001101100011, 63'h0, 1'b0};
    vecs[2] = '{1, {51{1'b1}}, 63'h0, 1'b0};
    vecs[3] = '{0, 51'({$urandom(), $urandom()}), 63'h0, 1'b0};
    vecs[4] = '{1, 51'({$urandom(), $urandom()}), 63'h0, 1'b1};
    for (int i = 1; i < 5; i++) vecs[i].exp = bch_cw(vecs[i].msg);
    rst = 0;
    req_valid = 0;
    req_msg = '0;
    cw_ready = 1;
    repeat (3) cyc();
    chk({req_ready, enc_valid, enc_bit, cw_valid, err_timeout} == 0, "reset_ctrl", {req_ready, enc_valid, enc_bit, cw_valid, err_timeout}, 0);
    chk(cw_data == 0, "reset_cw_data", cw_data, 0);
    chk(cw_id == 0, "reset_cw_id", cw_id, 0);
    rst = 1;
    cyc();
    for (int i = 0; i < 5; i++) run_frame(vecs[i].rid, vecs[i].msg, vecs[i].exp, vecs[i].tog);
    // Backpressure in OUT while requester 1 waits
    m0 = 51'({$urandom(), $urandom()});
    m1 = 51'({$urandom(), $urandom()});
    e0 = bch_cw(m0);
    req_msg = {m1, m0};
    cw_ready = 0;
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b10;
    n = 0;
    while (!cw_valid && n < 400) begin
      cyc();
      n++;
    end
    chk(cw_valid, "bp_reach_out", cw_valid, 1);
    repeat (20) begin
      cyc();
      chk(cw_valid && cw_data == e0 && cw_id == 0, "bp_hold", cw_data, e0);
      chk(req_ready == 0, "bp_busy", req_ready, 0);
    end
    cw_ready = 1;
    cyc();
    chk(req_ready == 2'b10, "rr_next", req_ready, 2'b10);
    cyc();
    req_valid = 0;
    n = 0;
    while (!cw_valid && n < 400) begin
      cyc();
      n++;
    end
    chk(cw_valid && cw_id == 1, "bp_second_frame", cw_id, 1);
    cyc();
    // Encoder stalls after 40 output bits: drain watchdog must fire
    stop_at = 40;
    req_msg[50:0] = 51'({$urandom(), $urandom()});
    req_valid = 2'b01;
    cyc();
    req_valid = 0;
    n = 0;
    while (enc_valid && n < 200) begin
      cyc();
      n++;
    end
    n = 0;
    while (!err_timeout && n < 400) begin
      cyc();
      n++;
    end
    chk(n == 255, "timeout_cycles", n, 255);
    chk(!cw_valid && !enc_valid, "timeout_idle", {cw_valid, enc_valid}, 0);
    cyc();
    chk(!err_timeout, "timeout_pulse_width", err_timeout, 0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    flush = 1;
    stop_at = -1;
    repeat (2) cyc();
    flush = 0;
    // Reset in the middle of FEED
    req_msg[101:51] = 51'({$urandom(), $urandom()});
    req_valid = 2'b10;
    cyc();
    req_valid = 0;
    repeat (12) cyc();
    chk(enc_valid && cw_id == 1, "mid_feed", {enc_valid, cw_id}, 2'b11);
    rst = 0;
    flush = 1;
    #1;
    chk({req_ready, enc_valid, enc_bit, cw_valid, err_timeout} == 0, "rst_mid_ctrl", {req_ready, enc_valid, enc_bit, cw_valid, err_timeout}, 0);
    chk(cw_data == 0, "rst_mid_cw_data", cw_data, 0);
    chk(cw_id == 0, "rst_mid_cw_id", cw_id, 0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    repeat (2) cyc();
    flush = 0;
    rst = 1;
    cyc();
    // Both requesters held valid: round-robin 0,1,0,1 from a reset pointer
    req_msg = {51'({$urandom(), $urandom()}), 51'({$urandom(), $urandom()})};
    f0 = frames;
    g0 = glog.size();
    req_valid = 2'b11;
    n = 0;
    while (frames < f0 + 4 && n < 2000) begin
      cyc();
      n++;
    end
    req_valid = 0;
    chk(frames == f0 + 4, "rr_frames", frames - f0, 4);
    for (int i = 0; i < 4; i++)
      if (glog.size() > g0 + i) chk(glog[g0+i] == i % 2, "rr_order", glog[g0+i], i % 2);
      else chk(0, "rr_order_missing", i, 4);
    repeat (5) cyc();
    chk(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfails);
    $finish;
  end
endmodule
